// File: rtl/input_reader_buffer.sv
// Single-packet store-and-forward buffer: stores one stream packet, acks it, replays it on fetch.
// Latency: ack_o one cycle after the last input beat; output_tvalid two cycles after fetch_data_in.
// Backpressure: data_ready_out low while a packet is held or replayed; replay stalls on output_tready.
// Optional compile macro INPUT_READER_LEN_CHECK_EN discards packets whose beat count differs from data_len_in.
module input_reader_buffer #(
    parameter int DATA_WIDTH        = 64,
    parameter int DATA_LENGTH_WIDTH = 20,
    parameter int RAM_ADDR_WIDTH    = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_WIDTH-1:0]        data_in,
    input  logic                         data_valid_in,
    input  logic [DATA_WIDTH/8-1:0]      data_keep_in,
    input  logic [DATA_LENGTH_WIDTH-1:0] data_len_in,
    input  logic                         data_last_in,
    output logic                         data_ready_out,
    output logic                         ack_o,
    input  logic                         fetch_data_in,
    input  logic                         output_tready,
    output logic [DATA_WIDTH-1:0]        output_tdata,
    output logic                         output_tvalid,
    output logic [DATA_WIDTH/8-1:0]      output_tkeep,
    output logic                         output_tlast
);
    localparam int KW = DATA_WIDTH / 8;
    localparam int AW = RAM_ADDR_WIDTH;

    typedef enum logic [2:0] {IDLE, WRITE, HOLD, READ, DROP} state_t;

    state_t                 state;
    logic [AW-1:0]          wr_addr;
    logic [AW-1:0]          rd_addr;
    logic [AW-1:0]          rd_addr_nxt;
    logic [AW-1:0]          last_idx;
    logic [AW-1:0]          end_idx;
    logic [KW+DATA_WIDTH-1:0] ram [2**AW];
    logic [KW+DATA_WIDTH-1:0] rd_dat_q;
    logic                   accept;
    logic                   wr_en;
    logic                   out_xfer;
    logic                   pkt_ok;

    assign accept   = data_valid_in && data_ready_out;
    assign wr_en    = accept && (state == IDLE || state == WRITE);
    assign out_xfer = output_tvalid && output_tready;
    // Index of the final stored beat if the current beat closes the packet.
    assign end_idx  = (state == DROP) ? '1 : wr_addr;

`ifdef INPUT_READER_LEN_CHECK_EN
    logic [DATA_LENGTH_WIDTH-1:0] len_q;
    logic [DATA_LENGTH_WIDTH-1:0] len_cur;
    logic [AW:0]                  end_cnt;

    assign len_cur = (state == IDLE) ? data_len_in : len_q;
    assign end_cnt = {1'b0, end_idx} + (AW+1)'(1);
    assign pkt_ok  = (len_cur == DATA_LENGTH_WIDTH'(end_cnt));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_q <= '0;
        end else if (accept && state == IDLE) begin
            len_q <= data_len_in;
        end
    end
`else
    logic unused_len;
    assign unused_len = ^data_len_in;
    assign pkt_ok     = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram[wr_addr] <= {data_keep_in, data_in};
        end
    end

    // The read address only advances on a transfer, so the registered read data doubles
    // as the prefetch stage and holds the bus steady during a stall.
    always_comb begin
        rd_addr_nxt = rd_addr;
        if (state == READ && out_xfer && !output_tlast) begin
            rd_addr_nxt = rd_addr + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_dat_q <= '0;
        end else begin
            rd_dat_q <= ram[rd_addr_nxt];
        end
    end

    assign {output_tkeep, output_tdata} = rd_dat_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            wr_addr        <= '0;
            rd_addr        <= '0;
            last_idx       <= '0;
            data_ready_out <= 1'b0;
            ack_o          <= 1'b0;
            output_tvalid  <= 1'b0;
            output_tlast   <= 1'b0;
        end else begin
            ack_o   <= 1'b0;
            rd_addr <= rd_addr_nxt;
            case (state)
                IDLE, WRITE: begin
                    data_ready_out <= 1'b1;
                    if (accept) begin
                        if (data_last_in) begin
                            wr_addr <= '0;
                            if (pkt_ok) begin
                                state          <= HOLD;
                                last_idx       <= end_idx;
                                data_ready_out <= 1'b0;
                                ack_o          <= 1'b1;
                            end else begin
                                state <= IDLE;
                            end
                        end else if (wr_addr == '1) begin
                            wr_addr <= '0;
                            state   <= DROP;
                        end else begin
                            wr_addr <= wr_addr + AW'(1);
                            state   <= WRITE;
                        end
                    end
                end
                DROP: begin
                    if (accept && data_last_in) begin
                        if (pkt_ok) begin
                            state          <= HOLD;
                            last_idx       <= end_idx;
                            data_ready_out <= 1'b0;
                            ack_o          <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                HOLD: begin
                    if (fetch_data_in) begin
                        state <= READ;
                    end
                end
                READ: begin
                    if (!output_tvalid) begin
                        output_tvalid <= 1'b1;
                        output_tlast  <= (last_idx == '0);
                    end else if (out_xfer) begin
                        if (output_tlast) begin
                            output_tvalid  <= 1'b0;
                            output_tlast   <= 1'b0;
                            rd_addr        <= '0;
                            data_ready_out <= 1'b1;
                            state          <= IDLE;
                        end else begin
                            output_tlast <= (rd_addr + AW'(1) == last_idx);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_input_reader_buffer.sv
// Directed bench for input_reader_buffer: store, ack, replay, stall, single beat, overflow, reset abort.
module tb_input_reader_buffer;
    logic        clk;
    logic        reset;
    logic [63:0] data_in;
    logic        data_valid_in;
    logic [7:0]  data_keep_in;
    logic [19:0] data_len_in;
    logic        data_last_in;
    logic        data_ready_out;
    logic        ack_o;
    logic        fetch_data_in;
    logic        output_tready;
    logic [63:0] output_tdata;
    logic        output_tvalid;
    logic [7:0]  output_tkeep;
    logic        output_tlast;

    int checks = 0;
    int errors = 0;
    logic [71:0] exp_mem [1024];
    int exp_n = 0;

    input_reader_buffer dut (
        .clk            (clk),
        .reset          (reset),
        .data_in        (data_in),
        .data_valid_in  (data_valid_in),
        .data_keep_in   (data_keep_in),
        .data_len_in    (data_len_in),
        .data_last_in   (data_last_in),
        .data_ready_out (data_ready_out),
        .ack_o          (ack_o),
        .fetch_data_in  (fetch_data_in),
        .output_tready  (output_tready),
        .output_tdata   (output_tdata),
        .output_tvalid  (output_tvalid),
        .output_tkeep   (output_tkeep),
        .output_tlast   (output_tlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0: data 1..n-1 then n-1 repeated on the last beat; mode 1: {base, beat index}
    task automatic send_pkt(input int n, input logic [7:0] keep, input int mode, input int base);
        logic [63:0] d;
        int t;
        exp_n = (n > 1024) ? 1024 : n;
        for (int i = 0; i < n; i++) begin
            t = 0;
            while (!data_ready_out && t < 50) begin
                step();
                t++;
            end
            if (!data_ready_out) begin
                chk("send_ready_wait", {95'd0, data_ready_out}, 96'd1);
                break;
            end
            d = (mode == 0) ? ((i < n - 1) ? 64'(i + 1) : 64'(n - 1)) : {32'(base), 32'(i)};
            data_in       = d;
            data_keep_in  = keep;
            data_valid_in = 1'b1;
            data_last_in  = (i == n - 1);
            data_len_in   = 20'(n);
            if (i < 1024) exp_mem[i] = {keep, d};
            step();
        end
        data_valid_in = 1'b0;
        data_last_in  = 1'b0;
    endtask

    task automatic check_ack(input string tag);
        chk({tag, "_ack"}, {95'd0, ack_o}, 96'd1);
        chk({tag, "_rdy_low"}, {95'd0, data_ready_out}, 96'd0);
        step();
        chk({tag, "_ack_once"}, {95'd0, ack_o}, 96'd0);
    endtask

    task automatic replay(input string tag, input bit toggle);
        int idx, bad, stall_bad, cyc;
        bit rdy, prev_stall;
        logic [73:0] prev_bus;
        idx = 0; bad = 0; stall_bad = 0; cyc = 0; prev_stall = 0; prev_bus = '0;
        fetch_data_in = 1'b1;
        step();
        fetch_data_in = 1'b0;
        chk({tag, "_vld_lat1"}, {95'd0, output_tvalid}, 96'd0);
        step();
        chk({tag, "_vld_lat2"}, {95'd0, output_tvalid}, 96'd1);
        while (idx < exp_n && cyc < 5000) begin
            rdy = toggle ? (cyc % 2 == 0) : 1'b1;
            output_tready = rdy;
            if (prev_stall && {output_tvalid, output_tlast, output_tkeep, output_tdata} !== prev_bus)
                stall_bad++;
            if (output_tvalid && rdy) begin
                if ({output_tkeep, output_tdata} !== exp_mem[idx] || output_tlast !== (idx == exp_n - 1))
                    bad++;
                idx++;
            end
            prev_stall = output_tvalid && !rdy;
            prev_bus   = {output_tvalid, output_tlast, output_tkeep, output_tdata};
            step();
            cyc++;
        end
        output_tready = 1'b0;
        chk({tag, "_beats"}, 96'(idx), 96'(exp_n));
        chk({tag, "_bad_beats"}, 96'(bad), 96'd0);
        chk({tag, "_stall_hold"}, 96'(stall_bad), 96'd0);
        chk({tag, "_done_vld"}, {95'd0, output_tvalid}, 96'd0);
        chk({tag, "_done_rdy"}, {95'd0, data_ready_out}, 96'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; data_in = '0; data_valid_in = 1'b0; data_keep_in = '0; data_len_in = '0;
        data_last_in = 1'b0; fetch_data_in = 1'b0; output_tready = 1'b0;
        repeat (3) step();
        chk("rst_rdy", {95'd0, data_ready_out}, 96'd0);
        chk("rst_ack", {95'd0, ack_o}, 96'd0);
        chk("rst_vld", {95'd0, output_tvalid}, 96'd0);
        chk("rst_last", {95'd0, output_tlast}, 96'd0);
        chk("rst_data", {32'd0, output_tdata}, 96'd0);
        chk("rst_keep", {88'd0, output_tkeep}, 96'd0);
        reset = 1'b1;
        chk("rel_rdy_before_edge", {95'd0, data_ready_out}, 96'd0);
        step();
        chk("rel_rdy_after_edge", {95'd0, data_ready_out}, 96'd1);

        // fetch while idle must be ignored
        fetch_data_in = 1'b1;
        step();
        fetch_data_in = 1'b0;
        repeat (2) step();
        chk("idle_fetch_vld", {95'd0, output_tvalid}, 96'd0);

        send_pkt(268, 8'hff, 0, 0);
        check_ack("p268");
        replay("rp268", 1'b0);

        send_pkt(268, 8'hff, 1, 32'h1111);
        check_ack("p268b");
        replay("rp_toggle", 1'b1);

        send_pkt(1, 8'h0f, 1, 32'hDEAD);
        check_ack("p1");
        replay("rp1", 1'b0);

        send_pkt(1030, 8'ha5, 1, 32'h2222);
        check_ack("p1030");
        replay("rp1030", 1'b1);

        // abort a replay with reset
        send_pkt(10, 8'hff, 1, 32'h3333);
        check_ack("p10");
        fetch_data_in = 1'b1;
        step();
        fetch_data_in = 1'b0;
        step();
        output_tready = 1'b1;
        repeat (3) step();
        chk("pre_abort_vld", {95'd0, output_tvalid}, 96'd1);
        reset = 1'b0;
        #1;
        chk("abort_vld", {95'd0, output_tvalid}, 96'd0);
        chk("abort_last", {95'd0, output_tlast}, 96'd0);
        chk("abort_data", {32'd0, output_tdata}, 96'd0);
        chk("abort_rdy", {95'd0, data_ready_out}, 96'd0);
        output_tready = 1'b0;
        step();
        reset = 1'b1;
        step();
        chk("post_abort_rdy", {95'd0, data_ready_out}, 96'd1);
        send_pkt(3, 8'h3c, 1, 32'h4444);
        check_ack("p3");
        replay("rp3", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
